// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the iterative multiply/divide unit:
// operation codes, datapath width and the MDU state encoding.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] MUL_RES    = 5'b01011;
  localparam logic [4:0] MULH_RES   = 5'b01100;
  localparam logic [4:0] MULHSU_RES = 5'b01101;
  localparam logic [4:0] MULHU_RES  = 5'b01110;
  localparam logic [4:0] DIV_RES    = 5'b01111;
  localparam logic [4:0] DIVU_RES   = 5'b10000;
  localparam logic [4:0] REM_RES    = 5'b10001;
  localparam logic [4:0] REMU_RES   = 5'b10010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } mdu_state_t;

  function automatic logic is_mdu_op(input logic [4:0] sel);
    return (sel >= MUL_RES) && (sel <= REMU_RES);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step,
// quotient shifted in from the right, partial remainder kept alongside.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dvs_reg;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;

  // Borrow out of the trial subtraction means the divisor did not fit.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_reg};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      quo_reg <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
    end else if (load) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      dvs_reg <= divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_reg <= diff[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
      end else begin
        rem_reg <= rem_shift[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, sign fixed up at the end, START/BUSY/DONE handshake.
module mdu_iterative #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  import alu_pkg::*;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  mdu_state_t        state_reg, state_next;
  logic [4:0]        op_reg;
  logic [XLEN-1:0]   a_reg, b_reg;
  logic              special_reg;
  logic [XLEN-1:0]   spec_val_reg;
  logic              prep_reg;
  logic [CW-1:0]     cnt_reg;
  logic [2*XLEN-1:0] mcand_reg, acc_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [XLEN-1:0]   result_reg;

  logic              accept;
  logic              in_is_div, in_is_rem, in_div_signed;
  logic              div_zero, div_ovf, special_in;
  logic [XLEN-1:0]   special_val;
  logic              is_div, is_rem, a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [XLEN-1:0]   a_mag, b_mag, quotient, remainder, quo_fix, rem_fix;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   fix_val;

  assign accept = (state_reg == S_IDLE) && START && !FLUSH && is_mdu_op(SELECT);

  // Division special cases are resolved straight from the request operands.
  always_comb begin
    in_is_div     = (SELECT >= DIV_RES);
    in_is_rem     = (SELECT == REM_RES) || (SELECT == REMU_RES);
    in_div_signed = (SELECT == DIV_RES) || (SELECT == REM_RES);
    div_zero      = in_is_div && (DATA2 == '0);
    div_ovf       = in_div_signed && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
    special_in    = div_zero || div_ovf;
    special_val   = '0;
    if (div_zero)     special_val = in_is_rem ? DATA1 : '1;
    else if (div_ovf) special_val = in_is_rem ? '0 : DATA1;
  end

  always_comb begin
    is_div   = (op_reg >= DIV_RES);
    is_rem   = (op_reg == REM_RES) || (op_reg == REMU_RES);
    a_signed = op_reg inside {MUL_RES, MULH_RES, MULHSU_RES, DIV_RES, REM_RES};
    b_signed = op_reg inside {MUL_RES, MULH_RES, DIV_RES, REM_RES};
    a_neg    = a_signed && a_reg[XLEN-1];
    b_neg    = b_signed && b_reg[XLEN-1];
    a_mag    = a_neg ? -a_reg : a_reg;
    b_mag    = b_neg ? -b_reg : b_reg;
    // A remainder follows the dividend's sign; everything else the XOR.
    res_neg  = is_rem ? a_neg : (a_neg ^ b_neg);
    product  = res_neg ? -acc_reg : acc_reg;
    quo_fix  = res_neg ? -quotient : quotient;
    rem_fix  = res_neg ? -remainder : remainder;
    if (special_reg)          fix_val = spec_val_reg;
    else if (is_div)          fix_val = is_rem ? rem_fix : quo_fix;
    else if (op_reg == MUL_RES) fix_val = product[XLEN-1:0];
    else                      fix_val = product[2*XLEN-1:XLEN];
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = special_in ? S_FIXUP : S_CALC;
      S_CALC:  if (prep_reg && (cnt_reg == CNT_LAST)) state_next = S_FIXUP;
      S_FIXUP: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (FLUSH) state_next = S_IDLE;
  end

  // The first CALC cycle forms the operand magnitudes; XLEN steps follow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      special_reg  <= 1'b0;
      spec_val_reg <= '0;
      prep_reg     <= 1'b0;
      cnt_reg      <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      result_reg   <= '0;
    end else begin
      prep_reg <= (state_reg == S_CALC) && !FLUSH;
      if (accept) begin
        op_reg       <= SELECT;
        a_reg        <= DATA1;
        b_reg        <= DATA2;
        special_reg  <= special_in;
        spec_val_reg <= special_val;
        cnt_reg      <= '0;
      end
      if (state_reg == S_CALC) begin
        if (!prep_reg) begin
          mcand_reg  <= {{XLEN{1'b0}}, a_mag};
          mplier_reg <= b_mag;
          acc_reg    <= '0;
        end else begin
          if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
        end
      end
      if ((state_reg == S_FIXUP) && !FLUSH) result_reg <= fix_val;
    end
  end

  mdu_div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (CLK),
    .srst      (RESET),
    .load      ((state_reg == S_CALC) && !prep_reg),
    .step      ((state_reg == S_CALC) && prep_reg),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign BUSY   = (state_reg != S_IDLE);
  assign DONE   = (state_reg == S_DONE);
  assign RESULT = result_reg;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed ops push expected results,
// a monitor pops and compares result and latency on every DONE pulse.
module tb_mdu_iterative;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [4:0]  SELECT;
  logic [31:0] DATA1, DATA2;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  mdu_iterative #(.XLEN(32)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .FLUSH  (FLUSH),
    .SELECT (SELECT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          issue;
    int          lat;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  int          completed = 0;
  logic [31:0] last_res = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every DONE must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET === 1'b0 && DONE === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, DONE}, 32'h0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, RESULT, e.val);
        check({e.name, "_latency"}, cyc - e.issue - 1, e.lat);
        $display("op %s: result=0x%08h latency=%0d", e.name, RESULT, cyc - e.issue - 1);
        completed++;
      end
    end
  end

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (completed < target && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_completion"}, completed, target);
  endtask

  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    SELECT = sel;
    DATA1  = a;
    DATA2  = b;
    START  = 1'b1;
  endtask

  task automatic do_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
    int target;
    target = completed + 1;
    issue(sel, a, b);
    sb.push_back('{exp, cyc, lat, name});
    last_res = exp;
    @(negedge CLK);
    START  = 1'b0;
    SELECT = 5'($urandom);
    DATA1  = $urandom;
    DATA2  = $urandom;
    wait_done(target, name);
    @(negedge CLK);
  endtask

  initial begin
    int target;
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    SELECT = 5'b0; DATA1 = 32'h0; DATA2 = 32'h0;
    repeat (3) @(negedge CLK);
    check("reset_busy", {31'b0, BUSY}, 32'h0);
    check("reset_done", {31'b0, DONE}, 32'h0);
    check("reset_result", RESULT, 32'h0);
    RESET = 1'b0;

    do_op(MUL_RES, 32'h10, 32'h20, 32'h00000200, 34, "mul");
    check("mul_busy_after_done", {31'b0, BUSY}, 32'h0);

    do_op(MULH_RES,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh");
    do_op(MULHSU_RES, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 34, "mulhsu");
    do_op(MULHU_RES,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu");

    do_op(DIV_RES,  32'hFFFFFFF0, 32'h2, 32'hFFFFFFF8, 34, "div");
    do_op(DIVU_RES, 32'hFFFFFFF0, 32'h2, 32'h7FFFFFF8, 34, "divu");
    do_op(REM_RES,  32'hFFFFFFF9, 32'h5, 32'hFFFFFFFE, 34, "rem");
    do_op(REMU_RES, 32'h17,       32'h5, 32'h00000003, 34, "remu");

    do_op(DIV_RES,  32'h7,        32'h0,        32'hFFFFFFFF, 1, "div_by_zero");
    do_op(REMU_RES, 32'h7,        32'h0,        32'h00000007, 1, "remu_by_zero");
    do_op(DIV_RES,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_overflow");
    do_op(REM_RES,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_overflow");

    // START pulsed mid-divide must be ignored.
    target = completed + 1;
    issue(DIV_RES, 32'd100, 32'd7);
    sb.push_back('{32'd14, cyc, 34, "div_start_abuse"});
    last_res = 32'd14;
    repeat (10) @(negedge CLK);
    START = 1'b0;
    issue(MUL_RES, 32'd3, 32'd3);
    @(negedge CLK);
    START = 1'b0;
    wait_done(target, "div_start_abuse");
    repeat (40) @(negedge CLK);
    check("abuse_idle_busy", {31'b0, BUSY}, 32'h0);

    issue(5'b00001, 32'd5, 32'd6);
    @(negedge CLK);
    START = 1'b0;
    check("invalid_sel_busy", {31'b0, BUSY}, 32'h0);
    repeat (3) @(negedge CLK);
    check("invalid_sel_busy_later", {31'b0, BUSY}, 32'h0);

    issue(MUL_RES, 32'd5, 32'd6);
    FLUSH = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    FLUSH = 1'b0;
    check("flush_start_busy", {31'b0, BUSY}, 32'h0);

    // FLUSH during a MULHU: no DONE, previous RESULT kept.
    issue(MULHU_RES, 32'h12345678, 32'h9ABCDEF0);
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_busy", {31'b0, BUSY}, 32'h0);
    check("flush_result", RESULT, last_res);
    repeat (40) @(negedge CLK);
    check("flush_result_later", RESULT, last_res);

    issue(MUL_RES, 32'h1234, 32'h10);
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midop_reset_busy", {31'b0, BUSY}, 32'h0);
    check("midop_reset_done", {31'b0, DONE}, 32'h0);
    check("midop_reset_result", RESULT, 32'h0);

    do_op(MUL_RES, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFF1, 34, "mul_after_reset");
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
